// File: rtl/path_rom_sequencer_if.sv
// Bus bundle between the path consumer, the path ROM and path_rom_sequencer.
// The slave modport is the sequencer's view; the master modport is the view of
// the surrounding logic (command source, ROM and consumer).
interface path_rom_sequencer_if;
  logic       iSTART;
  logic [8:0] iBASE;
  logic [9:0] iLENGTH;
  logic [8:0] oROM_ADDRESS;
  logic [9:0] iROM_DATA;
  logic [9:0] oDATA;
  logic       oVALID;
  logic       iREADY;
  logic       oLAST;
  logic       oBUSY;
  logic       oDONE;
  logic       oERROR;

  modport slave (
    input  iSTART, iBASE, iLENGTH, iROM_DATA, iREADY,
    output oROM_ADDRESS, oDATA, oVALID, oLAST, oBUSY, oDONE, oERROR
  );

  modport master (
    output iSTART, iBASE, iLENGTH, iROM_DATA, iREADY,
    input  oROM_ADDRESS, oDATA, oVALID, oLAST, oBUSY, oDONE, oERROR
  );
endinterface

// File: rtl/path_rom_sequencer.sv
// path_rom_sequencer: streams a contiguous run of 10-bit samples from a
// registered-read path ROM to a ready/valid consumer through a 2-entry FIFO.
// Optional build macro PATH_WRAP_EN: addresses wrap modulo 512; without it a
// run that would cross the top of the ROM is rejected with oERROR.
//
// state | meaning
// IDLE  | waiting for iSTART, validates the command
// RUN   | issuing ROM reads (credit limited)
// DRAIN | all reads issued, FIFO still holds data
// DONE  | one cycle, oDONE=1, then IDLE
module path_rom_sequencer #(
  parameter int DEPTH = 512
) (
  input logic CLK,
  input logic RESET,
  path_rom_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, next_state;
  logic [AW-1:0]   addr;
  logic [LW-1:0]   remaining;
  logic            inflight;
  logic            inflight_last;
  logic            error_q;
  logic [9:0]      buf_data [2];
  logic            buf_last [2];
  logic [1:0]      count;
  logic            rd_ptr;
  logic            wr_ptr;

  logic            cmd_ok;
  logic            accept;
  logic            xfer;
  logic            issue;
  logic [2:0]      occupancy;
  logic [2:0]      limit;

  // Command validation: length range plus, without wrapping, the ROM top bound.
  always_comb begin
    cmd_ok = (bus.iLENGTH != '0) && (bus.iLENGTH <= LW'(DEPTH));
`ifndef PATH_WRAP_EN
    if ({2'b00, bus.iBASE} + {1'b0, bus.iLENGTH} > (LW+1)'(DEPTH))
      cmd_ok = 1'b0;
`endif
  end

  // Read credit: the FIFO may hold two words. A beat leaving this cycle frees
  // a slot in time for a read issued now, which keeps one sample per clock.
  always_comb begin
    accept    = (state == IDLE) && bus.iSTART && cmd_ok;
    xfer      = (count != 2'd0) && bus.iREADY;
    occupancy = {1'b0, count} + {2'b00, inflight};
    limit     = xfer ? 3'd3 : 3'd2;
    issue     = (state == RUN) && (occupancy < limit);
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (issue && remaining == LW'(1)) next_state = DRAIN;
      DRAIN:   if (xfer && buf_last[rd_ptr]) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Address/issue counters, in-flight tracking and the error pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      if (accept) begin
        addr      <= bus.iBASE;
        remaining <= bus.iLENGTH;
      end else if (issue) begin
        remaining <= remaining - LW'(1);
`ifdef PATH_WRAP_EN
        addr <= addr + AW'(1);
`else
        // Hold on the final read so the address never rolls past the top.
        if (remaining != LW'(1)) addr <= addr + AW'(1);
`endif
      end
      inflight      <= issue;
      inflight_last <= issue && (remaining == LW'(1));
      error_q       <= (state == IDLE) && bus.iSTART && !cmd_ok;
    end
  end

  // Two-entry output FIFO: capture the ROM word one cycle after its read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      if (inflight) begin
        buf_data[wr_ptr] <= bus.iROM_DATA;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (xfer) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, xfer};
    end
  end

  assign bus.oROM_ADDRESS = addr;
  assign bus.oDATA        = buf_data[rd_ptr];
  assign bus.oVALID       = (count != 2'd0);
  assign bus.oLAST        = (count != 2'd0) && buf_last[rd_ptr];
  assign bus.oBUSY        = (state == RUN) || (state == DRAIN);
  assign bus.oDONE        = (state == DONE);
  assign bus.oERROR       = error_q;

endmodule

// File: tb/tb_path_rom_sequencer.sv
// Directed bench for path_rom_sequencer with a registered ROM model and a
// scoreboard queue of expected {last, data} beats.
module tb_path_rom_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   beats;
  int   done_seen;
  int   ready_mode;
  int   ready_phase;
  longint t_e0;
  logic [10:0] exp_q[$];
  logic        hold_valid;
  logic [9:0]  hold_data;

  path_rom_sequencer_if bus();

  path_rom_sequencer #(.DEPTH(512)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] rom_val(int a);
    return 10'((a * 37 + 11) % 1024);
  endfunction

  // Registered-read ROM: word for the address of the previous cycle.
  always @(posedge clk) bus.iROM_DATA <= rom_val(int'(bus.oROM_ADDRESS));

  function automatic bit legal(int b, int l);
    if (l < 1 || l > 512) return 1'b0;
`ifndef PATH_WRAP_EN
    if (b + l > 512) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer ready driver: mode 0 always ready, mode 1 pattern 1,0,0 repeating.
  initial begin
    bus.iREADY = 1'b1;
    ready_phase = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) bus.iREADY = 1'b1;
      else begin
        bus.iREADY = (ready_phase % 3 == 0);
        ready_phase++;
      end
    end
  end

  // Monitor: beats transfer on the next posedge when valid && ready here.
  initial begin
    logic [10:0] e;
    hold_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.oDONE) done_seen++;
        if (hold_valid) begin
          check("hold_valid", bus.oVALID, 1);
          check("hold_data", bus.oDATA, hold_data);
          hold_valid = 1'b0;
        end
        if (bus.oVALID && bus.iREADY) begin
          if (exp_q.size() == 0) check("unexpected_beat", bus.oVALID, 0);
          else begin
            e = exp_q.pop_front();
            check("beat_data", bus.oDATA, e[9:0]);
            check("beat_last", bus.oLAST, e[10]);
          end
          beats++;
        end else if (bus.oVALID) begin
          hold_valid = 1'b1;
          hold_data  = bus.oDATA;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a command at the next edge (E0), queue expected beats, check the
  // cycle right after E0.
  task automatic start(int b, int l);
    bit ok;
    ok = legal(b, l);
    bus.iSTART  = 1'b1;
    bus.iBASE   = 9'(b);
    bus.iLENGTH = 10'(l);
    if (ok)
      for (int i = 0; i < l; i++)
        exp_q.push_back({(i == l - 1), rom_val((b + i) % 512)});
    @(posedge clk);
    t_e0 = $time;
    #1;
    bus.iSTART = 1'b0;
    check("start_busy", bus.oBUSY, ok);
    check("start_error", bus.oERROR, !ok);
    if (ok) check("start_addr", bus.oROM_ADDRESS, b);
    else begin
      check("err_valid", bus.oVALID, 0);
      step();
      check("err_pulse_end", bus.oERROR, 0);
    end
  endtask

  task automatic wait_done(string tag, int budget, int exp_cycles);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (bus.oDONE) found = 1'b1;
    end
    check({tag, "_done_seen"}, found, 1);
    if (found) begin
      if (exp_cycles >= 0)
        check({tag, "_latency"}, 32'((($time - 1) - t_e0) / 10), exp_cycles);
      check({tag, "_busy_low"}, bus.oBUSY, 0);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      step();
      check({tag, "_done_pulse"}, bus.oDONE, 0);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_addr"}, bus.oROM_ADDRESS, 0);
    check({tag, "_data"}, bus.oDATA, 0);
    check({tag, "_valid"}, bus.oVALID, 0);
    check({tag, "_last"}, bus.oLAST, 0);
    check({tag, "_busy"}, bus.oBUSY, 0);
    check({tag, "_done"}, bus.oDONE, 0);
    check({tag, "_error"}, bus.oERROR, 0);
  endtask

  initial begin
    int b0;
    int d0;
    checks = 0; errors = 0; beats = 0; done_seen = 0; ready_mode = 0;
    rst = 1'b1;
    bus.iSTART = 1'b0; bus.iBASE = '0; bus.iLENGTH = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Basic run with first-beat latency.
    start(5, 4);
    check("basic_valid_e1", bus.oVALID, 0);
    step();
    check("basic_valid_e2", bus.oVALID, 0);
    step();
    check("basic_valid_e3", bus.oVALID, 1);
    check("basic_first", bus.oDATA, rom_val(5));
    wait_done("basic", 20, 4 + 2);

    // Length errors then a legal command.
    start(0, 0);
    check("len0_busy", bus.oBUSY, 0);
    start(0, 513);
    check("len513_busy", bus.oBUSY, 0);
    start(40, 3);
    wait_done("after_err", 20, 3 + 2);

    // Wrap boundary.
    start(510, 4);
`ifdef PATH_WRAP_EN
    wait_done("wrap", 20, 4 + 2);
`else
    repeat (3) step();
    check("nowrap_valid", bus.oVALID, 0);
    check("nowrap_busy", bus.oBUSY, 0);
    check("nowrap_addr", bus.oROM_ADDRESS, 40 + 2);
`endif

    // iSTART while busy is ignored.
    start(100, 6);
    step();
    bus.iSTART = 1'b1; bus.iBASE = 9'd300; bus.iLENGTH = 10'd3;
    step();
    bus.iSTART = 1'b0;
    check("busy_no_err", bus.oERROR, 0);
    wait_done("busy_ign", 30, 6 + 2);

    // Backpressure.
    ready_mode = 1;
    start(0, 8);
    wait_done("bp", 100, -1);
    ready_mode = 0;
    step();

    // Reset after 3 beats of a 10-beat run.
    b0 = beats;
    start(20, 10);
    for (int i = 0; i < 50 && beats - b0 < 3; i++) @(negedge clk);
    check("rst_three_beats", beats - b0, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    hold_valid = 1'b0;
    #1;
    check_reset_outputs("midrun");
    d0 = done_seen;
    step();
    rst = 1'b0;
    repeat (6) step();
    check("midrun_no_done", done_seen, d0);
    check("midrun_valid", bus.oVALID, 0);
    start(7, 2);
    wait_done("post_rst", 20, 2 + 2);

    // Full-length run.
    start(0, 512);
    wait_done("full", 600, 512 + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
